// File: rtl/int_sched_pkg.sv
// Shared definitions for the interrupt scheduler: FSM encoding and named source slots.
package int_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_e;

    localparam int SRC_TIMER = 0;
    localparam int SRC_EXT   = 1;
    localparam int SRC_KEY   = 2;
    localparam int SRC_SPARE = 3;

endpackage

// File: rtl/int_sched_prio_enc.sv
// Lowest-index-wins priority encoder; idx is 0 when nothing is requesting.
module int_prio_enc #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_SRC-1:0] req,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx = req[i] ? ID_W'(i) : idx;
        end
    end

endmodule

// File: rtl/int_sched.sv
// Interrupt scheduler: latches source edges, applies mask and fixed priority,
// issues one request at a time and tracks the running ISR via push/pop strobes.
module int_sched
    import int_sched_pkg::*;
#(
    parameter int              N_SRC      = 4,
    parameter int              ID_W       = 2,
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] VEC_BASE   = 10'h3C0,
    parameter int              VEC_STRIDE = 4,
    parameter int              DEPTH_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic              mask_we,
    input  logic [N_SRC-1:0]  mask_in,
    input  logic              push_in,
    input  logic              pop_in,
    output logic              int_req,
    output logic [PC_W-1:0]   int_vector,
    output logic              in_service,
    output logic [ID_W-1:0]   active_id,
    output logic [N_SRC-1:0]  pending,
    output logic              nest_err
);

    state_e               state_r, state_s;
    logic [N_SRC-1:0]     irq_prev_r, pending_r, mask_r;
    logic [DEPTH_W-1:0]   depth_r, depth_s;
    logic                 nest_err_r, int_req_r, in_service_r;
    logic [ID_W-1:0]      active_id_r;
    logic [PC_W-1:0]      int_vector_r;

    logic [N_SRC-1:0]     edge_s, eligible_s, clr_s;
    logic                 any_s, accept_s, err_set_s;
    logic [ID_W-1:0]      win_s;
    logic [PC_W-1:0]      vec_s;

    assign edge_s     = irq_in & ~irq_prev_r;
    assign eligible_s = pending_r & mask_r;
    assign vec_s      = VEC_BASE + PC_W'(int'(win_s) * VEC_STRIDE);

    int_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req (eligible_s),
        .any (any_s),
        .idx (win_s)
    );

    // Next-state, acceptance and nested-call depth tracking.
    always_comb begin
        state_s   = state_r;
        depth_s   = depth_r;
        clr_s     = '0;
        accept_s  = 1'b0;
        err_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                err_set_s = pop_in;
                if (any_s) begin
                    state_s  = REQ;
                    accept_s = 1'b1;
                    clr_s    = N_SRC'(1) << win_s;
                    depth_s  = '0;
                end else begin
                    state_s  = IDLE;
                end
            end
            REQ: begin
                // The push seen here is the entry push of the ISR itself.
                err_set_s = pop_in;
                state_s   = SERVICE;
            end
            SERVICE: begin
                if (push_in && !pop_in) begin
                    if (depth_r == '1) begin
                        err_set_s = 1'b1;
                    end else begin
                        depth_s = depth_r + DEPTH_W'(1);
                    end
                end else if (pop_in && !push_in) begin
                    if (depth_r != '0) begin
                        depth_s = depth_r - DEPTH_W'(1);
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    depth_s = depth_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, pending latch, mask and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            irq_prev_r   <= '0;
            pending_r    <= '0;
            mask_r       <= '0;
            depth_r      <= '0;
            nest_err_r   <= 1'b0;
            int_req_r    <= 1'b0;
            in_service_r <= 1'b0;
            active_id_r  <= '0;
            int_vector_r <= VEC_BASE;
        end else begin
            state_r      <= state_s;
            irq_prev_r   <= irq_in;
            // A new edge wins over the acceptance clear on the same bit.
            pending_r    <= (pending_r & ~clr_s) | edge_s;
            depth_r      <= depth_s;
            int_req_r    <= (state_s == REQ);
            in_service_r <= (state_s != IDLE);
            if (mask_we) begin
                mask_r <= mask_in;
            end
            if (err_set_s) begin
                nest_err_r <= 1'b1;
            end
            if (accept_s) begin
                active_id_r  <= win_s;
                int_vector_r <= vec_s;
            end
        end
    end

    assign int_req    = int_req_r;
    assign int_vector = int_vector_r;
    assign in_service = in_service_r;
    assign active_id  = active_id_r;
    assign pending    = pending_r;
    assign nest_err   = nest_err_r;

endmodule

// File: tb/tb_int_sched.sv
// Randomised + directed bench for int_sched with a behavioural model and a request scoreboard.
module tb_int_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in, mask_in;
    logic       mask_we, push_in, pop_in;
    logic       int_req, in_service, nest_err;
    logic [9:0] int_vector;
    logic [1:0] active_id;
    logic [3:0] pending;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [9:0] vec; logic [1:0] id; } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;

    // Model of the scheduler as the control unit sees it.
    bit [3:0] m_pend, m_prev, m_mask;
    bit       m_busy, m_req, m_err;
    int       m_depth;
    bit [9:0] m_vec;
    bit [1:0] m_id;
    bit       done = 1'b0;
    bit       fin  = 1'b0;

    int_sched dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .push_in    (push_in),
        .pop_in     (pop_in),
        .int_req    (int_req),
        .int_vector (int_vector),
        .in_service (in_service),
        .active_id  (active_id),
        .pending    (pending),
        .nest_err   (nest_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 4'b0; m_prev = 4'b0; m_mask = 4'b0;
        m_busy = 1'b0; m_req = 1'b0; m_err = 1'b0;
        m_depth = 0; m_vec = 10'h3C0; m_id = 2'd0;
    endtask

    task automatic model_step(input bit [3:0] irq, input bit we, input bit [3:0] msk,
                              input bit pu, input bit po);
        bit [3:0] edg, clr;
        int w;
        edg = irq & ~m_prev;
        clr = 4'b0;
        if (!m_busy) begin
            w = -1;
            for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) w = i;
            if (po) m_err = 1'b1;
            if (w >= 0) begin
                clr[w]  = 1'b1;
                m_busy  = 1'b1;
                m_req   = 1'b1;
                m_depth = 0;
                m_vec   = 10'(960 + w * 4);
                m_id    = 2'(w);
                sb_q.push_back('{m_vec, m_id});
            end
        end else if (m_req) begin
            m_req = 1'b0;
            if (po) m_err = 1'b1;
        end else begin
            if (pu && !po) begin
                if (m_depth == 15) m_err = 1'b1;
                else m_depth++;
            end else if (po && !pu) begin
                if (m_depth > 0) m_depth--;
                else m_busy = 1'b0;
            end
        end
        m_pend = (m_pend & ~clr) | edg;
        m_prev = irq;
        if (we) m_mask = msk;
    endtask

    // Drive one cycle of inputs; the model advances on the same edge as the DUT.
    task automatic step(input logic [3:0] irq, input logic we, input logic [3:0] msk,
                        input logic pu, input logic po);
        irq_in = irq; mask_we = we; mask_in = msk; push_in = pu; pop_in = po;
        @(posedge clk);
        model_step(irq, we, msk, pu, po);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    task automatic set_mask(input logic [3:0] msk);
        step(4'b0, 1'b1, msk, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
    endtask

    task automatic push1();
        step(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        irq_in = 4'b0; mask_we = 1'b0; mask_in = 4'b0; push_in = 1'b0; pop_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compares every output each negedge and pops the scoreboard on a request.
    always @(negedge clk) begin
        check("int_req", {31'b0, int_req}, {31'b0, m_req});
        check("in_service", {31'b0, in_service}, {31'b0, m_busy});
        check("pending", {28'b0, pending}, {28'b0, m_pend});
        check("nest_err", {31'b0, nest_err}, {31'b0, m_err});
        check("int_vector", {22'b0, int_vector}, {22'b0, m_vec});
        check("active_id", {30'b0, active_id}, {30'b0, m_id});
        if (int_req === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_req: got int_req=1 expected no request at %0t", $time);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_vector", {22'b0, int_vector}, {22'b0, sb_e.vec});
                check("sb_id", {30'b0, active_id}, {30'b0, sb_e.id});
            end
        end
        if (done && !fin) begin
            check("sb_drained", sb_q.size(), 32'd0);
            fin = 1'b1;
        end
    end

    initial begin
        bit [3:0] r_irq;
        int       r;
        reset = 1'b1;
        irq_in = 4'b0; mask_we = 1'b0; mask_in = 4'b0; push_in = 1'b0; pop_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single source, highest priority.
        set_mask(4'b0001);
        idle(2);
        step(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(4);
        pop1();
        idle(2);

        // Simultaneous edges on 2 and 1: 1 first, then 2 after one idle cycle.
        set_mask(4'b1111);
        step(4'b0110, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(4);
        pop1();
        idle(4);
        pop1();
        idle(2);

        // Masked source latches but waits for the mask.
        set_mask(4'b0000);
        step(4'b1000, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(4);
        set_mask(4'b1000);
        idle(4);
        pop1();
        idle(2);

        // Nested calls inside an ISR.
        set_mask(4'b1111);
        step(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(3);
        push1(); push1(); pop1(); pop1(); pop1();
        idle(2);
        step(4'b0010, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(3);
        step(4'b0, 1'b0, 4'b0, 1'b1, 1'b1);
        pop1();
        idle(2);

        // Depth saturation: 16 pushes, then 15 pops keep service, the 16th ends it.
        step(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(3);
        repeat (16) push1();
        repeat (15) pop1();
        idle(1);
        pop1();
        idle(2);

        // Stray pop while idle.
        do_reset();
        idle(1);
        pop1();
        idle(2);

        // Reset in the middle of service with source 2 pending.
        set_mask(4'b1111);
        step(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(3);
        step(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(2);
        do_reset();
        idle(5);

        // Randomised traffic.
        set_mask(4'($urandom_range(1, 15)));
        r_irq = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
            if (m_busy && !m_req && $urandom_range(0, 299) == 0) begin
                do_reset();
                r_irq = 4'b0;
            end else begin
                r = int'($urandom_range(0, 9));
                if (m_busy && !m_req)
                    step(r_irq, ($urandom_range(0, 31) == 0), 4'($urandom),
                         (r <= 1 || r == 5), (r >= 2 && r <= 5));
                else
                    step(r_irq, ($urandom_range(0, 31) == 0), 4'($urandom),
                         ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
            end
        end
        idle(4);
        done = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
